// File: rtl/copro_dispatch.sv
// copro_dispatch: handshaked dispatcher between the decode stage and NUM_UNITS
// iterative coprocessors (unit 0 = gcd, unit 1 = lcm, unit u on opcode OPBASE+u).
// One instruction is in flight at a time: IDLE -> START -> WAIT -> WB -> IDLE.
// Optional feature macro: COPRO_TIMEOUT_EN adds a WAIT watchdog that forces a
// zero-data writeback with err_o after TIMEOUT cycles without done_i.
module copro_dispatch #(
    parameter int          WIDTH     = 32,
    parameter int          NUM_UNITS = 2,
    parameter logic [6:0]  OPBASE    = 7'b0000000,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_i,
    input  logic [6:0]                    op_i,
    input  logic [4:0]                    rd_i,
    input  logic [WIDTH-1:0]              srca_i,
    input  logic [WIDTH-1:0]              srcb_i,
    input  logic                          flush_i,
    output logic                          stall_o,
    output logic [NUM_UNITS-1:0]          start_o,
    output logic [WIDTH-1:0]              opa_o,
    output logic [WIDTH-1:0]              opb_o,
    input  logic [NUM_UNITS-1:0]          done_i,
    input  logic [NUM_UNITS*WIDTH-1:0]    result_i,
    output logic                          wb_valid_o,
    output logic [4:0]                    wb_rd_o,
    output logic [WIDTH-1:0]              wb_data_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [UW-1:0]     unit_q, unit_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [4:0]        rd_q, rd_d;
    logic [WIDTH-1:0]  result_q, result_d;

    // Opcode range check done in 8 bits so OPBASE+NUM_UNITS cannot wrap.
    logic [7:0]        opExt;
    logic [7:0]        baseExt;
    logic [7:0]        limitExt;
    logic [6:0]        opOffset;
    logic              hit;

    assign opExt    = {1'b0, op_i};
    assign baseExt  = {1'b0, OPBASE};
    assign limitExt = baseExt + 8'(NUM_UNITS);
    assign opOffset = op_i - OPBASE;
    assign hit      = valid_i && (opExt >= baseExt) && (opExt < limitExt) && !flush_i;

    logic [NUM_UNITS-1:0] unitOneHot;
    logic                 unitDone;
    logic [WIDTH-1:0]     unitResult;

    // Select the latched unit's start bit, done strobe and result slice.
    always_comb begin
        unitOneHot = '0;
        unitDone   = 1'b0;
        unitResult = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_q == i[UW-1:0]) begin
                unitOneHot[i] = 1'b1;
                unitDone      = done_i[i];
                unitResult    = result_i[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef COPRO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmoCnt_q, tmoCnt_d;
    logic          err_q, err_d;

    // Next-state logic with the WAIT watchdog; a done on the limit cycle wins.
    always_comb begin
        state_d  = state_q;
        unit_d   = unit_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        result_d = result_q;
        tmoCnt_d = tmoCnt_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    unit_d  = opOffset[UW-1:0];
                    opa_d   = srca_i;
                    opb_d   = srcb_i;
                    rd_d    = rd_i;
                    state_d = START;
                end
            end
            START: begin
                tmoCnt_d = '0;
                err_d    = 1'b0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (unitDone) begin
                    result_d = unitResult;
                    err_d    = 1'b0;
                    state_d  = WB;
                end else if (tmoCnt_q == CW'(TIMEOUT - 1)) begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = WB;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end
    end

    // Watchdog counter and error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmoCnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            tmoCnt_q <= tmoCnt_d;
            err_q    <= err_d;
        end
    end

    assign err_o = (state_q == WB) && !flush_i && err_q;
`else
    logic unusedTimeout;
    assign unusedTimeout = |TIMEOUT;

    // Next-state logic; WAIT holds until the selected unit reports done.
    always_comb begin
        state_d  = state_q;
        unit_d   = unit_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    unit_d  = opOffset[UW-1:0];
                    opa_d   = srca_i;
                    opb_d   = srcb_i;
                    rd_d    = rd_i;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (unitDone) begin
                    result_d = unitResult;
                    state_d  = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    assign err_o = 1'b0;
`endif

    // State, latched instruction fields and captured result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            unit_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    // Stall is gated by reset because the IDLE term depends on live inputs.
    assign stall_o    = reset && (((state_q == IDLE) && hit) ||
                                  (state_q == START) || (state_q == WAIT));
    assign start_o    = ((state_q == START) && !flush_i) ? unitOneHot : '0;
    assign opa_o      = opa_q;
    assign opb_o      = opb_q;
    assign busy_o     = (state_q != IDLE);
    assign wb_valid_o = (state_q == WB) && !flush_i && (rd_q != 5'd0);
    assign wb_rd_o    = ((state_q == WB) && !flush_i) ? rd_q : 5'd0;
    assign wb_data_o  = ((state_q == WB) && !flush_i) ? result_q : '0;

endmodule

// File: tb/tb_copro_dispatch.sv
// tb_copro_dispatch: directed self-checking bench for copro_dispatch.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_copro_dispatch;

    localparam int WIDTH     = 32;
    localparam int NUM_UNITS = 2;

    logic                       clk;
    logic                       reset;
    logic                       valid_i;
    logic [6:0]                 op_i;
    logic [4:0]                 rd_i;
    logic [WIDTH-1:0]           srca_i;
    logic [WIDTH-1:0]           srcb_i;
    logic                       flush_i;
    logic                       stall_o;
    logic [NUM_UNITS-1:0]       start_o;
    logic [WIDTH-1:0]           opa_o;
    logic [WIDTH-1:0]           opb_o;
    logic [NUM_UNITS-1:0]       done_i;
    logic [NUM_UNITS*WIDTH-1:0] result_i;
    logic                       wb_valid_o;
    logic [4:0]                 wb_rd_o;
    logic [WIDTH-1:0]           wb_data_o;
    logic                       busy_o;
    logic                       err_o;

    int total = 0;
    int bad   = 0;

    copro_dispatch #(
        .WIDTH     (WIDTH),
        .NUM_UNITS (NUM_UNITS),
        .OPBASE    (7'b0000000),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .op_i       (op_i),
        .rd_i       (rd_i),
        .srca_i     (srca_i),
        .srcb_i     (srcb_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .start_o    (start_o),
        .opa_o      (opa_o),
        .opb_o      (opb_o),
        .done_i     (done_i),
        .result_i   (result_i),
        .wb_valid_o (wb_valid_o),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b);
        valid_i = v;
        op_i    = op;
        rd_i    = rd;
        srca_i  = a;
        srcb_i  = b;
    endtask

    // Full operation: issue, start, done after 'delay' WAIT cycles, writeback, back to idle.
    task automatic runOp(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int delay,
                         input bit spurious);
        int unit;
        unit = int'(op);
        step();
        applyStimulus(1'b1, op, rd, a, b);
        #1;
        checkOutput("issueStall", 32'(stall_o), 32'd1);
        checkOutput("issueBusy", 32'(busy_o), 32'd0);
        step();
        applyStimulus(1'b0, 7'd0, 5'd0, 32'd0, 32'd0);
        #1;
        checkOutput("startVec", 32'(start_o), 32'(1 << unit));
        checkOutput("startStall", 32'(stall_o), 32'd1);
        checkOutput("opA", opa_o, a);
        checkOutput("opB", opb_o, b);
        for (int k = 1; k <= delay; k++) begin
            step();
            done_i   = '0;
            result_i = '0;
            if (k == delay) begin
                done_i[unit]                 = 1'b1;
                result_i[unit*WIDTH +: WIDTH] = res;
            end else if (spurious && k == 1) begin
                done_i[1-unit]                   = 1'b1;
                result_i[(1-unit)*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
            end
            #1;
            checkOutput("waitStart", 32'(start_o), 32'd0);
            checkOutput("waitStall", 32'(stall_o), 32'd1);
            checkOutput("waitWb", 32'(wb_valid_o), 32'd0);
        end
        step();
        done_i   = '0;
        result_i = '0;
        #1;
        checkOutput("wbValid", 32'(wb_valid_o), (rd != 5'd0) ? 32'd1 : 32'd0);
        checkOutput("wbRd", 32'(wb_rd_o), 32'(rd));
        checkOutput("wbData", wb_data_o, res);
        checkOutput("wbStall", 32'(stall_o), 32'd0);
        checkOutput("wbErr", 32'(err_o), 32'd0);
        step();
        #1;
        checkOutput("idleWb", 32'(wb_valid_o), 32'd0);
        checkOutput("idleBusy", 32'(busy_o), 32'd0);
        checkOutput("holdOpA", opa_o, a);
    endtask

    initial begin
        reset    = 1'b0;
        flush_i  = 1'b0;
        done_i   = '0;
        result_i = '0;
        applyStimulus(1'b0, 7'd0, 5'd0, 32'd0, 32'd0);
        #12;
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstStart", 32'(start_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // gcd(48,18)=6 into x5, done three cycles after start: five stalled cycles.
        runOp(7'd0, 5'd5, 32'd48, 32'd18, 32'd6, 3, 1'b0);

        // lcm(4,6)=12 with a spurious unit-0 done before the real unit-1 done.
        runOp(7'd1, 5'd7, 32'd4, 32'd6, 32'd12, 2, 1'b1);

        // rd=x0: full operation, writeback suppressed.
        runOp(7'd0, 5'd0, 32'd9, 32'd6, 32'd3, 1, 1'b0);

        // Opcode just past the unit range is ignored.
        step();
        applyStimulus(1'b1, 7'd2, 5'd3, 32'd1, 32'd1);
        #1;
        checkOutput("missStall", 32'(stall_o), 32'd0);
        step();
        applyStimulus(1'b0, 7'd0, 5'd0, 32'd0, 32'd0);
        #1;
        checkOutput("missBusy", 32'(busy_o), 32'd0);
        checkOutput("missStart", 32'(start_o), 32'd0);

        // Flush during WAIT, then a late done: no writeback, then a clean gcd.
        step();
        applyStimulus(1'b1, 7'd0, 5'd4, 32'd10, 32'd4);
        step();
        applyStimulus(1'b0, 7'd0, 5'd0, 32'd0, 32'd0);
        step();
        flush_i = 1'b1;
        step();
        flush_i  = 1'b0;
        done_i   = 2'b01;
        result_i = 64'd2;
        #1;
        checkOutput("flushBusy", 32'(busy_o), 32'd0);
        checkOutput("flushWb", 32'(wb_valid_o), 32'd0);
        checkOutput("flushStall", 32'(stall_o), 32'd0);
        step();
        done_i   = '0;
        result_i = '0;
        #1;
        checkOutput("lateDoneWb", 32'(wb_valid_o), 32'd0);
        checkOutput("lateDoneBusy", 32'(busy_o), 32'd0);
        runOp(7'd0, 5'd9, 32'd21, 32'd14, 32'd7, 1, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        step();
        applyStimulus(1'b1, 7'd1, 5'd8, 32'd3, 32'd5);
        step();
        applyStimulus(1'b0, 7'd0, 5'd0, 32'd0, 32'd0);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arstStall", 32'(stall_o), 32'd0);
        checkOutput("arstBusy", 32'(busy_o), 32'd0);
        checkOutput("arstOpA", opa_o, 32'd0);
        checkOutput("arstOpB", opb_o, 32'd0);
        checkOutput("arstWb", {wb_valid_o, wb_rd_o, err_o}, 32'd0);
        checkOutput("arstData", wb_data_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        #1;
        checkOutput("arstIdle", 32'(busy_o), 32'd0);

`ifdef COPRO_TIMEOUT_EN
        // No done: forced writeback after 8 WAIT cycles with zero data and err_o.
        step();
        applyStimulus(1'b1, 7'd0, 5'd5, 32'd8, 32'd2);
        step();
        applyStimulus(1'b0, 7'd0, 5'd0, 32'd0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            #1;
            checkOutput("tmoWait", {wb_valid_o, err_o, busy_o}, 32'd1);
        end
        step();
        #1;
        checkOutput("tmoWb", 32'(wb_valid_o), 32'd1);
        checkOutput("tmoData", wb_data_o, 32'd0);
        checkOutput("tmoErr", 32'(err_o), 32'd1);
        step();
        #1;
        checkOutput("tmoIdle", {busy_o, err_o}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
